// File: rtl/piso_shifter_n.sv
// Parallel-in serial-out shifter: captures a WIDTH-bit word and emits it one bit per clock.
// Optional feature: define PISO_PARITY_EN to append an even-parity bit to every frame.
module piso_shifter_n #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] parallel_in,
    output logic             ready,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

`ifdef PISO_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

    function automatic logic first_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? (w << 1) : (w >> 1);
    endfunction

    state_t             state_p0, state_p1;
    logic [WIDTH-1:0]   shreg_p0, shreg_p1;
    logic [CNT_W-1:0]   cnt_p0, cnt_p1;
    logic               sout_p0, sout_p1;
    logic               vld_p0, vld_p1;
`ifdef PISO_PARITY_EN
    logic               par_p0, par_p1;
`endif

    always_comb begin
        state_p0 = state_p1;
        shreg_p0 = shreg_p1;
        cnt_p0   = cnt_p1;
        sout_p0  = 1'b0;
        vld_p0   = 1'b0;
`ifdef PISO_PARITY_EN
        par_p0   = par_p1;
        done     = (state_p1 == PARITY);
`else
        done     = (state_p1 == SHIFT) && (cnt_p1 == LAST_IDX);
`endif
        ready    = (state_p1 == IDLE) || done;

        case (state_p1)
            SHIFT: begin
                if (cnt_p1 != LAST_IDX) begin
                    shreg_p0 = advance(shreg_p1);
                    cnt_p0   = cnt_p1 + 1'b1;
                    sout_p0  = first_bit(advance(shreg_p1));
                    vld_p0   = 1'b1;
                end else begin
`ifdef PISO_PARITY_EN
                    state_p0 = PARITY;
                    sout_p0  = par_p1;
                    vld_p0   = 1'b1;
`else
                    state_p0 = IDLE;
`endif
                end
            end
`ifdef PISO_PARITY_EN
            PARITY: state_p0 = IDLE;
`endif
            default: state_p0 = IDLE;
        endcase

        // A capture in the done cycle overrides the return to IDLE, giving gap-free frames.
        if (load && ready) begin
            state_p0 = SHIFT;
            shreg_p0 = parallel_in;
            cnt_p0   = '0;
            sout_p0  = first_bit(parallel_in);
            vld_p0   = 1'b1;
`ifdef PISO_PARITY_EN
            par_p0   = ^parallel_in;
`endif
        end
    end

    // Stage boundary: all state and the serial output bit are registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_p1 <= IDLE;
            shreg_p1 <= '0;
            cnt_p1   <= '0;
            sout_p1  <= 1'b0;
            vld_p1   <= 1'b0;
`ifdef PISO_PARITY_EN
            par_p1   <= 1'b0;
`endif
        end else begin
            state_p1 <= state_p0;
            shreg_p1 <= shreg_p0;
            cnt_p1   <= cnt_p0;
            sout_p1  <= sout_p0;
            vld_p1   <= vld_p0;
`ifdef PISO_PARITY_EN
            par_p1   <= par_p0;
`endif
        end
    end

    assign serial_out   = sout_p1;
    assign serial_valid = vld_p1;

endmodule

// File: tb/tb_piso_shifter_n.sv
// Bench for piso_shifter_n (WIDTH=4): directed vector table, hand sequences, and a
// randomized run against a queue-based frame model for LSB-first and MSB-first instances.
module tb_piso_shifter_n;

    localparam int W = 4;
`ifdef PISO_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int FL = W + PAR;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] parallel_in = '0;
    logic         ready0, so0, sv0, done0;
    logic         ready1, so1, sv1, done1;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    piso_shifter_n #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst(rst), .load(load), .parallel_in(parallel_in),
        .ready(ready0), .serial_out(so0), .serial_valid(sv0), .done(done0)
    );

    piso_shifter_n #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .rst(rst), .load(load), .parallel_in(parallel_in),
        .ready(ready1), .serial_out(so1), .serial_valid(sv1), .done(done1)
    );

    // Frame model: the bit currently on the wire plus a queue of bits still to come.
    bit cur_v[2];
    bit cur_b[2];
    bit q0[$];
    bit q1[$];

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got {rdy,out,vld,done}=%b expected %b", name, $time, act, exp);
        end
    endtask

    task automatic model_step(input logic r, input logic l, input logic [W-1:0] w);
        for (int k = 0; k < 2; k++) begin
            bit fr[$];
            int qs;
            bit rdy;
            qs  = (k == 0) ? q0.size() : q1.size();
            rdy = !cur_v[k] || (qs == 0);
            if (r) begin
                cur_v[k] = 1'b0;
                if (k == 0) q0 = {}; else q1 = {};
            end else if (l && rdy) begin
                fr = {};
                for (int i = 0; i < W; i++) fr.push_back((k == 1) ? w[W-1-i] : w[i]);
                if (PAR == 1) fr.push_back(^w);
                cur_b[k] = fr.pop_front();
                cur_v[k] = 1'b1;
                if (k == 0) q0 = fr; else q1 = fr;
            end else if (qs != 0) begin
                cur_b[k] = (k == 0) ? q0.pop_front() : q1.pop_front();
                cur_v[k] = 1'b1;
            end else begin
                cur_v[k] = 1'b0;
            end
        end
    endtask

    function automatic logic [3:0] model_exp(input int k);
        int qs;
        qs = (k == 0) ? q0.size() : q1.size();
        return {(!cur_v[k] || qs == 0), (cur_v[k] && cur_b[k]), cur_v[k], (cur_v[k] && qs == 0)};
    endfunction

    // Apply inputs for one rising edge, then check both instances against the model.
    task automatic tick(input logic r, input logic l, input logic [W-1:0] w);
        rst = r;
        load = l;
        parallel_in = w;
        @(posedge clk);
        model_step(r, l, w);
        @(negedge clk);
        chk("model_lsb", {ready0, so0, sv0, done0}, model_exp(0));
        chk("model_msb", {ready1, so1, sv1, done1}, model_exp(1));
    endtask

    typedef struct packed {
        logic         r;
        logic         l;
        logic [W-1:0] w;
        logic [3:0]   exp;
    } vec_t;

    initial begin
        vec_t       tbl[26];
        logic [4:0] lsb_par_exp;
        logic [4:0] msb_exp;

        // exp = {ready, serial_out, serial_valid, done} for the LSB-first instance
        tbl = '{
            '{1'b1, 1'b0, 4'b0000, 4'b1000},
            '{1'b0, 1'b1, 4'b1101, 4'b0110},
            '{1'b0, 1'b0, 4'b0000, 4'b0010},
            '{1'b0, 1'b0, 4'b0000, 4'b0110},
            '{1'b0, 1'b0, 4'b0000, 4'b1111},
            '{1'b0, 1'b0, 4'b0000, 4'b1000},
            '{1'b0, 1'b1, 4'b1101, 4'b0110},
            '{1'b0, 1'b0, 4'b0000, 4'b0010},
            '{1'b0, 1'b0, 4'b0000, 4'b0110},
            '{1'b0, 1'b0, 4'b0000, 4'b1111},
            '{1'b0, 1'b1, 4'b0010, 4'b0010},
            '{1'b0, 1'b0, 4'b0000, 4'b0110},
            '{1'b0, 1'b0, 4'b0000, 4'b0010},
            '{1'b0, 1'b0, 4'b0000, 4'b1011},
            '{1'b0, 1'b0, 4'b0000, 4'b1000},
            '{1'b0, 1'b1, 4'b1101, 4'b0110},
            '{1'b0, 1'b0, 4'b0000, 4'b0010},
            '{1'b0, 1'b1, 4'b0000, 4'b0110},
            '{1'b0, 1'b0, 4'b0000, 4'b1111},
            '{1'b0, 1'b0, 4'b0000, 4'b1000},
            '{1'b0, 1'b1, 4'b1111, 4'b0110},
            '{1'b0, 1'b0, 4'b0000, 4'b0110},
            '{1'b1, 1'b0, 4'b0000, 4'b1000},
            '{1'b0, 1'b0, 4'b0000, 4'b1000},
            '{1'b1, 1'b1, 4'b1111, 4'b1000},
            '{1'b0, 1'b0, 4'b0000, 4'b1000}
        };
        lsb_par_exp = 5'b11101;
        msb_exp     = 5'b11011;

        cur_v = '{1'b0, 1'b0};
        cur_b = '{1'b0, 1'b0};

`ifndef PISO_PARITY_EN
        for (int i = 0; i < 26; i++) begin
            tick(tbl[i].r, tbl[i].l, tbl[i].w);
            chk($sformatf("vec%0d", i), {ready0, so0, sv0, done0}, tbl[i].exp);
        end
`else
        tick(1'b1, 1'b0, 4'b0000);
        chk("par_reset", {ready0, so0, sv0, done0}, 4'b1000);
        for (int i = 0; i < FL; i++) begin
            tick(1'b0, (i == 0), (i == 0) ? 4'b1101 : 4'b0000);
            chk($sformatf("par_bit%0d", i), {so0, sv0, done0}, {lsb_par_exp[i], 1'b1, (i == FL - 1)});
        end
        tick(1'b0, 1'b0, 4'b0000);
        chk("par_idle", {ready0, so0, sv0, done0}, 4'b1000);
`endif

        // MSB-first frame of 4'b1101
        tick(1'b1, 1'b0, 4'b0000);
        for (int i = 0; i < FL; i++) begin
            tick(1'b0, (i == 0), (i == 0) ? 4'b1101 : 4'b0000);
            chk($sformatf("msb_bit%0d", i), {so1, sv1, done1}, {msb_exp[i], 1'b1, (i == FL - 1)});
        end
        tick(1'b0, 1'b0, 4'b0000);
        chk("msb_idle", {ready1, so1, sv1, done1}, 4'b1000);

        // Randomized traffic, including occasional resets and loads while busy
        for (int n = 0; n < 400; n++) begin
            tick(($urandom_range(0, 39) == 0), ($urandom_range(0, 1) == 1), W'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/piso_shifter_n.md
PISO_SHIFTER_N -- requirements
Module: piso_shifter_n

Interface
REQ-001 Parameter WIDTH, default 8: parallel word width in bits; legal range 2 to 64.
REQ-002 Parameter MSB_FIRST, default 0: 0 = right shift (LSB transmitted first); 1 = left shift (MSB transmitted first).
REQ-003 Port clk, input, 1: the only clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1: reset, synchronous, active-high.
REQ-005 Port load, input, 1: request to capture parallel_in.
REQ-006 Port parallel_in, input, WIDTH: word to serialise.
REQ-007 Port ready, output, 1: block accepts load this cycle.
REQ-008 Port serial_out, output, 1: registered serial data bit.
REQ-009 Port serial_valid, output, 1: serial_out carries a valid bit this cycle.
REQ-010 Port done, output, 1: one-cycle pulse marking the final bit of the current frame.

Function
REQ-011 The block SHALL implement an FSM with states IDLE, SHIFT, and PARITY (PARITY exists only per REQ-026).
REQ-012 ready SHALL be 1 in IDLE and in the cycle in which done=1; ready SHALL be 0 in all other cycles.
REQ-013 Capture SHALL occur on a rising edge where load=1 and ready=1: the shift register loads parallel_in, the bit counter loads 0, and the FSM enters SHIFT.
REQ-014 A load asserted while ready=0 SHALL be ignored, with no effect on data, counter or state.
REQ-015 serial_out SHALL present the first bit (parallel_in[0] if MSB_FIRST=0, parallel_in[WIDTH-1] if MSB_FIRST=1) in the cycle after capture, giving a latency of 1 cycle.
REQ-016 Each subsequent rising edge in SHIFT SHALL advance one bit, so the frame is WIDTH consecutive cycles with serial_valid=1.
REQ-017 The bit counter SHALL be $clog2(WIDTH+1) bits wide and count 0 to WIDTH-1, with no wrap beyond WIDTH-1.
REQ-018 done SHALL be 1 exactly in the cycle the last bit of the frame is on serial_out.
REQ-019 After the last bit, if load=0 the FSM SHALL go to IDLE with serial_valid=0 and serial_out=0 on the next cycle.
REQ-020 If load=1 during the done cycle, the new word SHALL be captured on that edge and its first bit SHALL follow on the next cycle with no gap (back-to-back).
REQ-021 When serial_valid=0, serial_out SHALL be 0.
REQ-022 parallel_in changes after capture SHALL NOT affect the frame in progress.

Reset
REQ-023 While rst=1 at a rising edge, state SHALL become IDLE, the shift register and counter SHALL become 0, and outputs SHALL become ready=1, serial_out=0, serial_valid=0, done=0.
REQ-024 rst SHALL take priority over load; a simultaneous load is discarded.
REQ-025 rst asserted mid-frame SHALL abort the frame immediately at that edge; no remaining bits are emitted.

Configuration
REQ-026 With macro PISO_PARITY_EN defined, each frame SHALL append one even-parity bit (XOR of the captured word) in state PARITY after the WIDTH data bits, making the frame WIDTH+1 valid cycles, with done asserted on the parity bit.
REQ-027 Without PISO_PARITY_EN, the PARITY state and parity logic SHALL be absent, and frames SHALL be exactly WIDTH bits.

Verification (WIDTH=4)
REQ-028 With MSB_FIRST=0: rst for 1 cycle, then load 4'b1101 -> serial_out 1,0,1,1 over 4 cycles, serial_valid=1 throughout, done on the 4th, then idle with serial_out=0.
REQ-029 With MSB_FIRST=1: load 4'b1101 -> serial_out 1,1,0,1, with done on the 4th bit.
REQ-030 Back-to-back: load 4'b1101, then load 4'b0010 held during the done cycle (LSB first) -> 1,0,1,1,0,1,0,0 contiguous, with done pulses at bits 4 and 8.
REQ-031 Busy load: load 4'b1101, then pulse load with 4'b0000 at bit 2 -> pulse ignored, output 1,0,1,1, return to IDLE.
REQ-032 Mid-frame reset: load 4'b1111, assert rst at bit 2 -> next cycle serial_valid=0, serial_out=0, ready=1, no further bits.
REQ-033 With PISO_PARITY_EN defined: load 4'b1101 -> 1,0,1,1 then parity bit 1 (5 valid cycles), with done on the parity bit.
